// File: rtl/hdmi_pkg.sv
// Shared HDMI output-path types and frame-buffer geometry.
// Holds default frame-buffer size, address width and pixel formats.
package hdmi_pkg;

    localparam int FB_WIDTH  = 240;
    localparam int FB_HEIGHT = 320;
    localparam int FB_DEPTH  = FB_WIDTH * FB_HEIGHT;
    localparam int FB_ADDR_W = 18;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    // Replicating the top bits spreads 0..max evenly onto 0..255.
    function automatic rgb888_t expand565(input rgb565_t p);
        rgb888_t o;
        o.r = {p.r, p.r[4:2]};
        o.g = {p.g, p.g[5:4]};
        o.b = {p.b, p.b[4:2]};
        return o;
    endfunction

endpackage

// File: rtl/frame_fetch_delay_pipe.sv
// delay_pipe: fixed-depth shift register, async active-high clear.
// Ports: clk_in, rst_in, data_in[WIDTH], data_out[WIDTH] (DEPTH cycles late).
module delay_pipe #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        stage_d[0] = data_in;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign data_out = stage_q[DEPTH-1];

endmodule

// File: rtl/frame_fetch.sv
// frame_fetch: scaled coordinates -> double-buffered BRAM address -> RGB888.
// Ports: pixel clock/reset, scaler coords+valid, raster syncs, frame_done,
// BRAM address/data, RGB888 + latency-matched syncs, displayed bank.
module frame_fetch #(
    parameter int FB_WIDTH     = 240,
    parameter int FB_HEIGHT    = 320,
    parameter int READ_LATENCY = 2
) (
    input  logic        clk_pixel_in,
    input  logic        rst_in,
    input  logic [10:0] scaled_hcount_in,
    input  logic [9:0]  scaled_vcount_in,
    input  logic        valid_addr_in,
    input  logic        active_draw_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        frame_done_in,
    output logic [17:0] bram_addr_out,
    input  logic [15:0] bram_data_in,
    output logic [7:0]  red_out,
    output logic [7:0]  green_out,
    output logic [7:0]  blue_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        active_draw_out,
    output logic        read_bank_out
);

    import hdmi_pkg::*;

    localparam int BANK_SIZE = FB_WIDTH * FB_HEIGHT;

    logic [FB_ADDR_W-1:0] addr_q, addr_d;
    logic [FB_ADDR_W-1:0] row_base, bank_base;
    logic                 in_range;
    logic                 read_bank_q, read_bank_d;
    logic                 swap_pending_q, swap_pending_d;
    logic                 vsync_prev_q;
    logic                 vsync_rise;
    logic [3:0]           band_in, band_dly;
    rgb888_t              pix_q, pix_d;
    logic                 hsync_q, vsync_q, active_q;

    // Out-of-range coordinates fall back to the bank base so the
    // read never leaves the displayed bank.
    always_comb begin
        in_range = valid_addr_in
                   && (int'(scaled_hcount_in) < FB_WIDTH)
                   && (int'(scaled_vcount_in) < FB_HEIGHT);
        if (FB_WIDTH == 240) begin
            row_base = (FB_ADDR_W'(scaled_vcount_in) << 8)
                     - (FB_ADDR_W'(scaled_vcount_in) << 4);
        end else begin
            row_base = FB_ADDR_W'(int'(scaled_vcount_in) * FB_WIDTH);
        end
        bank_base = read_bank_q ? FB_ADDR_W'(BANK_SIZE) : '0;
        addr_d = bank_base;
        if (in_range) begin
            addr_d = bank_base + row_base
                   + FB_ADDR_W'(scaled_hcount_in);
        end
    end

    // A completed frame arms a swap; the next vsync rise takes it.
    // A frame_done in the same cycle re-arms for the following frame.
    always_comb begin
        vsync_rise     = vsync_in && !vsync_prev_q;
        read_bank_d    = read_bank_q ^ (vsync_rise && swap_pending_q);
        swap_pending_d = frame_done_in
                         || (swap_pending_q && !vsync_rise);
    end

    // Stage-A flags ride alongside the address through the BRAM read.
    assign band_in = {in_range, active_draw_in, hsync_in, vsync_in};

    delay_pipe #(
        .WIDTH (4),
        .DEPTH (READ_LATENCY + 1)
    ) u_band_dly (
        .clk_in   (clk_pixel_in),
        .rst_in   (rst_in),
        .data_in  (band_in),
        .data_out (band_dly)
    );

    always_comb begin
        pix_d = '0;
        if (band_dly[3] && band_dly[2]) begin
            pix_d = expand565(rgb565_t'(bram_data_in));
        end
    end

    always_ff @(posedge clk_pixel_in or posedge rst_in) begin
        if (rst_in) begin
            addr_q         <= '0;
            read_bank_q    <= 1'b0;
            swap_pending_q <= 1'b0;
            vsync_prev_q   <= 1'b0;
            pix_q          <= '0;
            hsync_q        <= 1'b0;
            vsync_q        <= 1'b0;
            active_q       <= 1'b0;
        end else begin
            addr_q         <= addr_d;
            read_bank_q    <= read_bank_d;
            swap_pending_q <= swap_pending_d;
            vsync_prev_q   <= vsync_in;
            pix_q          <= pix_d;
            hsync_q        <= band_dly[1];
            vsync_q        <= band_dly[0];
            active_q       <= band_dly[2];
        end
    end

    assign bram_addr_out   = addr_q;
    assign read_bank_out   = read_bank_q;
    assign red_out         = pix_q.r;
    assign green_out       = pix_q.g;
    assign blue_out        = pix_q.b;
    assign hsync_out       = hsync_q;
    assign vsync_out       = vsync_q;
    assign active_draw_out = active_q;

endmodule

// File: tb/tb_frame_fetch.sv
// Randomized bench for frame_fetch at read latencies 1, 2 and 4.
// Outputs are compared to a cycle-indexed history of the stimulus.
module tb_frame_fetch;

    localparam int W    = 240;
    localparam int H    = 320;
    localparam int BANK = W * H;
    localparam int NMEM = 2 * BANK;
    localparam int HMAX = 4096;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [10:0] h = '0;
    logic [9:0]  v = '0;
    logic        vld = 1'b0, act = 1'b0, hs = 1'b0, vs = 1'b0, fd = 1'b0;

    logic [17:0] a1, a2, a4;
    logic [15:0] d1, d2, d4;
    logic [7:0]  r1, g1, b1, r2, g2, b2, r4, g4, b4;
    logic        hs1, vs1, ad1, bk1;
    logic        hs2, vs2, ad2, bk2;
    logic        hs4, vs4, ad4, bk4;

    logic [15:0] mem [NMEM];
    logic [17:0] ah2;
    logic [17:0] ah4 [3];

    int  addr_h [HMAX];
    int  bank_h [HMAX];
    bit  inr_h [HMAX];
    bit  act_h [HMAX];
    bit  hs_h [HMAX];
    bit  vs_h [HMAX];

    int cyc = 0;
    int last_rst = -1;
    int n_vec = 0;
    int n_err = 0;
    int m_bank = 0, m_pend = 0, m_vprev = 0;

    always #5 clk = ~clk;

    frame_fetch #(.READ_LATENCY(1)) u_l1 (
        .clk_pixel_in(clk), .rst_in(rst),
        .scaled_hcount_in(h), .scaled_vcount_in(v),
        .valid_addr_in(vld), .active_draw_in(act),
        .hsync_in(hs), .vsync_in(vs), .frame_done_in(fd),
        .bram_addr_out(a1), .bram_data_in(d1),
        .red_out(r1), .green_out(g1), .blue_out(b1),
        .hsync_out(hs1), .vsync_out(vs1),
        .active_draw_out(ad1), .read_bank_out(bk1)
    );

    frame_fetch #(.READ_LATENCY(2)) u_l2 (
        .clk_pixel_in(clk), .rst_in(rst),
        .scaled_hcount_in(h), .scaled_vcount_in(v),
        .valid_addr_in(vld), .active_draw_in(act),
        .hsync_in(hs), .vsync_in(vs), .frame_done_in(fd),
        .bram_addr_out(a2), .bram_data_in(d2),
        .red_out(r2), .green_out(g2), .blue_out(b2),
        .hsync_out(hs2), .vsync_out(vs2),
        .active_draw_out(ad2), .read_bank_out(bk2)
    );

    frame_fetch #(.READ_LATENCY(4)) u_l4 (
        .clk_pixel_in(clk), .rst_in(rst),
        .scaled_hcount_in(h), .scaled_vcount_in(v),
        .valid_addr_in(vld), .active_draw_in(act),
        .hsync_in(hs), .vsync_in(vs), .frame_done_in(fd),
        .bram_addr_out(a4), .bram_data_in(d4),
        .red_out(r4), .green_out(g4), .blue_out(b4),
        .hsync_out(hs4), .vsync_out(vs4),
        .active_draw_out(ad4), .read_bank_out(bk4)
    );

    function automatic logic [15:0] rd(input logic [17:0] a);
        if (int'(a) < NMEM) return mem[a];
        return 16'hDEAD;
    endfunction

    // BRAM models: data appears READ_LATENCY edges after the address.
    always @(posedge clk) begin
        d1     <= rd(a1);
        ah2    <= a2;
        d2     <= rd(ah2);
        ah4[0] <= a4;
        ah4[1] <= ah4[0];
        ah4[2] <= ah4[1];
        d4     <= rd(ah4[2]);
    end

    function automatic logic [23:0] exp_rgb(input logic [15:0] w);
        return {w[15:11], w[15:13], w[10:5], w[10:9], w[4:0], w[4:2]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h",
                     tag, cyc, got, exp);
        end
    endtask

    task automatic check_lat(input string tag, input int lat,
                             input logic [23:0] rgb,
                             input logic [2:0] sb);
        int s;
        logic [23:0] er;
        logic [2:0]  es;
        s  = cyc - lat;
        er = '0;
        es = '0;
        if (s >= 0 && s > last_rst) begin
            if (inr_h[s] && act_h[s]) er = exp_rgb(mem[addr_h[s]]);
            es = {hs_h[s], vs_h[s], act_h[s]};
        end
        chk({tag, "_rgb"}, 32'(rgb), 32'(er));
        chk({tag, "_sync"}, 32'(sb), 32'(es));
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        chk("addr_l1", 32'(a1), 32'(addr_h[cyc-1]));
        chk("addr_l2", 32'(a2), 32'(addr_h[cyc-1]));
        chk("addr_l4", 32'(a4), 32'(addr_h[cyc-1]));
        chk("bank_l2", 32'(bk2), 32'(bank_h[cyc-1]));
        check_lat("l1", 3, {r1, g1, b1}, {hs1, vs1, ad1});
        check_lat("l2", 4, {r2, g2, b2}, {hs2, vs2, ad2});
        check_lat("l4", 6, {r4, g4, b4}, {hs4, vs4, ad4});
    endtask

    task automatic apply(input bit r, input int hh, input int vv,
                         input bit vl, input bit ad, input bit hss,
                         input bit vss, input bit fdd);
        bit inr, rise;
        rst = r;
        h   = 11'(hh);
        v   = 10'(vv);
        vld = vl;
        act = ad;
        hs  = hss;
        vs  = vss;
        fd  = fdd;
        act_h[cyc] = ad;
        hs_h[cyc]  = hss;
        vs_h[cyc]  = vss;
        if (r) begin
            last_rst     = cyc;
            m_bank       = 0;
            m_pend       = 0;
            m_vprev      = 0;
            inr_h[cyc]   = 1'b0;
            addr_h[cyc]  = 0;
        end else begin
            inr = vl && (hh < W) && (vv < H);
            inr_h[cyc]  = inr;
            addr_h[cyc] = m_bank * BANK + (inr ? vv * W + hh : 0);
            rise = vss && (m_vprev == 0);
            if (rise && m_pend == 1) begin
                m_bank = 1 - m_bank;
                m_pend = 0;
            end
            if (fdd) m_pend = 1;
            m_vprev = int'(vss);
        end
        bank_h[cyc] = m_bank;
    endtask

    task automatic idle(input bit vss);
        apply(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, vss, 1'b0);
        tick();
    endtask

    initial begin
        for (int i = 0; i < NMEM; i++) mem[i] = 16'($urandom);
        mem[485] = 16'hF800;

        repeat (4) begin
            apply(1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        chk("rst_bank", 32'(bk4), 32'd0);
        repeat (2) idle(1'b0);

        apply(1'b0, 5, 2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk("addr_485", 32'(a2), 32'd485);
        repeat (3) idle(1'b0);
        chk("rgb_f800", 32'({r2, g2, b2}), 32'h00FF0000);

        apply(1'b0, 239, 319, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk("addr_76799", 32'(a2), 32'd76799);
        apply(1'b0, 240, 319, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk("addr_hedge", 32'(a2), 32'd0);
        repeat (3) idle(1'b0);
        chk("rgb_hedge", 32'({r2, g2, b2}), 32'd0);

        apply(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        apply(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        chk("bank_swap", 32'(bk1), 32'd1);
        apply(1'b0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        chk("addr_76800", 32'(a2), 32'd76800);
        idle(1'b0);
        idle(1'b1);
        chk("bank_hold", 32'(bk4), 32'd1);

        idle(1'b0);
        apply(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        chk("bank_coinc", 32'(bk2), 32'd1);
        idle(1'b0);
        idle(1'b1);
        chk("bank_next", 32'(bk2), 32'd0);

        for (int i = 0; i < 1800; i++) begin
            if (i == 900) begin
                repeat (3) begin
                    apply(1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
                    tick();
                end
            end
            apply(1'b0,
                  ($urandom_range(0, 15) == 0) ? 2047
                                               : $urandom_range(0, 250),
                  ($urandom_range(0, 15) == 0) ? 1023
                                               : $urandom_range(0, 330),
                  $urandom_range(0, 9) != 0,
                  1'($urandom),
                  1'($urandom),
                  1'($urandom),
                  $urandom_range(0, 7) == 0);
            tick();
        end
        repeat (8) idle(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
